// File: rtl/mac_pkg.sv
// mac_pkg -- shared constants and types for the MAC output stage.
//   EXP_W / FRAC_W : field widths of the packed output word
//   EXP_MAX        : largest representable biased exponent
//   SAT_MAG        : magnitude bits of the saturated (overflow) word
//   fifo_entry_t   : one output-buffer entry (packed word + tag)
package mac_pkg;

  localparam int EXP_W   = 6;
  localparam int FRAC_W  = 9;
  localparam int WORD_W  = 1 + EXP_W + FRAC_W;
  localparam int TAG_W   = 5;
  localparam int EXP_MAX = 63;

  localparam logic [EXP_W+FRAC_W-1:0] SAT_MAG = {EXP_W'(EXP_MAX), {FRAC_W{1'b1}}};

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [TAG_W-1:0]  q_frac;
  } fifo_entry_t;

endpackage

// File: rtl/mac_pack_round.sv
// mac_pack_round -- combinational exponent adjust, round-half-to-even and
// saturation of a normalized stage-4 result into the 16-bit output word.
// Ports:
//   norm_sum  [10:0] in  : normalized magnitude, bit 10 is the leading 1
//   exp_diff  [4:0]  in  : signed exponent adjustment
//   exp_carry        in  : +1 exponent adjustment
//   sgn              in  : result sign
//   max_exp   [5:0]  in  : biased block exponent
//   data      [15:0] out : {sign, exp, frac}
//   ovf / unf        out : saturation events for this word
module mac_pack_round
  import mac_pkg::*;
(
  input  logic [10:0]       norm_sum,
  input  logic [4:0]        exp_diff,
  input  logic              exp_carry,
  input  logic              sgn,
  input  logic [EXP_W-1:0]  max_exp,
  output logic [WORD_W-1:0] data,
  output logic              ovf,
  output logic              unf
);

  logic signed [7:0] e_base;
  logic signed [7:0] e_rnd;
  logic [FRAC_W:0]   frac_sum;
  logic              round_up;

  always_comb begin
    e_base = $signed({2'b00, max_exp}) + $signed({{3{exp_diff[4]}}, exp_diff})
           + $signed({7'd0, exp_carry});
    // Only one bit below the kept fraction, so a set bit 0 is always an exact
    // tie: round up only when that makes the kept LSB even.
    round_up = norm_sum[0] & norm_sum[1];
    frac_sum = {1'b0, norm_sum[9:1]} + {{FRAC_W{1'b0}}, round_up};
    // A carry out of the fraction means the mantissa became 2.0 -> renormalize.
    e_rnd    = e_base + $signed({7'd0, frac_sum[FRAC_W]});

    data = {sgn, e_rnd[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
    ovf  = 1'b0;
    unf  = 1'b0;
    if (norm_sum == 11'd0) begin
      data = {sgn, {(EXP_W+FRAC_W){1'b0}}};
    end else if (e_rnd <= 8'sd0) begin
      data = {sgn, {(EXP_W+FRAC_W){1'b0}}};
      unf  = 1'b1;
    end else if (e_rnd > 8'sd63) begin
      data = {sgn, SAT_MAG};
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_stg5.sv
// mac_stg5 -- MAC pipeline stage 5: packs/rounds the stage-4 result and
// buffers it in a 2-entry output FIFO with ready/valid downstream and an
// inhibit (stall) toward upstream; counts overflow/underflow saturations.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_valid, i_norm_sum, i_exp_diff, i_exp_carry, i_sgn, i_max_exp, i_Q_frac : stage-4 result
//   o_inhibit                    : FIFO full, upstream must hold
//   o_valid, i_ready, o_data, o_Q_frac : FIFO head / downstream handshake
//   i_clr_cnt, o_ovf_cnt, o_unf_cnt   : saturation event counters
module mac_stg5
  import mac_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [10:0]       i_norm_sum,
  input  logic [4:0]        i_exp_diff,
  input  logic              i_exp_carry,
  input  logic              i_sgn,
  input  logic [EXP_W-1:0]  i_max_exp,
  input  logic [TAG_W-1:0]  i_Q_frac,
  output logic              o_inhibit,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WORD_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_Q_frac,
  input  logic              i_clr_cnt,
  output logic [CNT_W-1:0]  o_ovf_cnt,
  output logic [CNT_W-1:0]  o_unf_cnt
);

  logic [WORD_W-1:0] packed_word;
  logic              ovf_evt;
  logic              unf_evt;
  fifo_entry_t       in_entry;
  fifo_entry_t       mem [FIFO_DEPTH];
  logic [1:0]        count_reg;
  logic              rd_ptr_reg;
  logic              wr_ptr_reg;
  logic [CNT_W-1:0]  ovf_cnt_reg;
  logic [CNT_W-1:0]  unf_cnt_reg;
  logic              push;
  logic              pop;

  mac_pack_round u_pack_round (
    .norm_sum  (i_norm_sum),
    .exp_diff  (i_exp_diff),
    .exp_carry (i_exp_carry),
    .sgn       (i_sgn),
    .max_exp   (i_max_exp),
    .data      (packed_word),
    .ovf       (ovf_evt),
    .unf       (unf_evt)
  );

  assign in_entry  = '{data: packed_word, q_frac: i_Q_frac};
  assign o_valid   = (count_reg != 2'd0);
  assign o_inhibit = (count_reg == 2'(FIFO_DEPTH));
  assign push      = i_valid && !o_inhibit;
  assign pop       = o_valid && i_ready;
  assign o_data    = mem[rd_ptr_reg].data;
  assign o_Q_frac  = mem[rd_ptr_reg].q_frac;
  assign o_ovf_cnt = ovf_cnt_reg;
  assign o_unf_cnt = unf_cnt_reg;

  // Storage slots: written only when the write pointer selects them, so the
  // head stays stable while downstream stalls.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        mem[gi] <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        mem[gi] <= in_entry;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= !wr_ptr_reg;
      if (pop)  rd_ptr_reg <= !rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_cnt_reg <= '0;
      unf_cnt_reg <= '0;
    end else if (i_clr_cnt) begin
      ovf_cnt_reg <= '0;
      unf_cnt_reg <= '0;
    end else begin
      if (push && ovf_evt && !(&ovf_cnt_reg)) ovf_cnt_reg <= ovf_cnt_reg + CNT_W'(1);
      if (push && unf_evt && !(&unf_cnt_reg)) unf_cnt_reg <= unf_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mac_stg5.sv
// tb_mac_stg5 -- self-checking bench for mac_stg5 with a scoreboard queue.
module tb_mac_stg5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [10:0] i_norm_sum = '0;
  logic [4:0]  i_exp_diff = '0;
  logic        i_exp_carry = 1'b0;
  logic        i_sgn = 1'b0;
  logic [5:0]  i_max_exp = '0;
  logic [4:0]  i_Q_frac = '0;
  logic        i_ready = 1'b1;
  logic        i_clr_cnt = 1'b0;
  logic        o_inhibit;
  logic        o_valid;
  logic [15:0] o_data;
  logic [4:0]  o_Q_frac;
  logic [15:0] o_ovf_cnt;
  logic [15:0] o_unf_cnt;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  q;
  } sb_t;

  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_ovf = 0;
  int   m_unf = 0;
  bit   rand_rdy = 1'b0;

  always #5 clk = ~clk;

  mac_stg5 #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .i_norm_sum  (i_norm_sum),
    .i_exp_diff  (i_exp_diff),
    .i_exp_carry (i_exp_carry),
    .i_sgn       (i_sgn),
    .i_max_exp   (i_max_exp),
    .i_Q_frac    (i_Q_frac),
    .o_inhibit   (o_inhibit),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_Q_frac    (o_Q_frac),
    .i_clr_cnt   (i_clr_cnt),
    .o_ovf_cnt   (o_ovf_cnt),
    .o_unf_cnt   (o_unf_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic logic [15:0] model(input logic [10:0] n, input logic [4:0] d,
                                        input logic c, input logic s, input logic [5:0] m,
                                        output int of, output int uf);
    int e;
    int mant;
    logic [15:0] r;
    e    = int'(m) + int'($signed(d)) + int'(c);
    mant = (int'(n) % 1024) / 2;
    of   = 0;
    uf   = 0;
    if ((int'(n) % 2 == 1) && (mant % 2 == 1)) mant++;
    if (mant == 512) begin
      mant = 0;
      e++;
    end
    if (n == 11'd0) begin
      r = {s, 15'd0};
    end else if (e <= 0) begin
      r = {s, 15'd0};
      uf = 1;
    end else if (e > 63) begin
      r = {s, 15'h7FFF};
      of = 1;
    end else begin
      r = {s, 6'(e), 9'(mant)};
    end
    return r;
  endfunction

  // Monitor: compares pops against the scoreboard, checks head stability
  // under backpressure, and records accepted inputs.
  initial begin
    bit          hold_prev = 1'b0;
    logic [20:0] prev_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        m_ovf = 0;
        m_unf = 0;
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) check("hold_head", {11'd0, o_Q_frac, o_data}, {11'd0, prev_word});
        if (o_valid && i_ready) begin
          if (sb.size() == 0) begin
            check("pop_unexpected", 32'(o_valid), 32'd0);
          end else begin
            sb_t e;
            e = sb.pop_front();
            check("pop_data", 32'(o_data), 32'(e.data));
            check("pop_q", 32'(o_Q_frac), 32'(e.q));
            $display("pop data=%04h q=%0d exp_data=%04h exp_q=%0d", o_data, o_Q_frac, e.data, e.q);
          end
        end
        hold_prev = o_valid && !i_ready;
        prev_word = {o_Q_frac, o_data};
        if (i_clr_cnt) begin
          m_ovf = 0;
          m_unf = 0;
        end
        if (i_valid && !o_inhibit) begin
          sb_t e;
          int  of;
          int  uf;
          e.data = model(i_norm_sum, i_exp_diff, i_exp_carry, i_sgn, i_max_exp, of, uf);
          e.q    = i_Q_frac;
          sb.push_back(e);
          if (!i_clr_cnt) begin
            m_ovf += of;
            m_unf += uf;
          end
        end
      end
    end
  end

  task automatic set_in(input logic [10:0] n, input logic [4:0] d, input logic c,
                        input logic s, input logic [5:0] m, input logic [4:0] q);
    i_valid     = 1'b1;
    i_norm_sum  = n;
    i_exp_diff  = d;
    i_exp_carry = c;
    i_sgn       = s;
    i_max_exp   = m;
    i_Q_frac    = q;
  endtask

  // Holds the current input until the edge that accepts it (bounded).
  task automatic wait_accept();
    bit took;
    int n;
    n = 0;
    do begin
      took = !o_inhibit;
      @(posedge clk);
      #1;
      if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
      n++;
    end while (!took && n < 50);
    if (!took) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [10:0] n, input logic [4:0] d, input logic c,
                      input logic s, input logic [5:0] m, input logic [4:0] q);
    set_in(n, d, c, s, m, q);
    wait_accept();
  endtask

  task automatic idle(input int cycles);
    i_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_inhibit", 32'(o_inhibit), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_q", 32'(o_Q_frac), 32'd0);
    check("rst_ovf_cnt", 32'(o_ovf_cnt), 32'd0);
    check("rst_unf_cnt", 32'(o_unf_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-to-even tie stays down; one-cycle latency from empty
    send(11'h401, 5'd0, 1'b0, 1'b0, 6'd20, 5'd1);
    check("lat_valid", 32'(o_valid), 32'd1);
    check("rte_data", 32'(o_data), 32'h2800);
    // Tie rounds up and overflows mantissa -> exponent + 1
    send(11'h7FF, 5'd0, 1'b0, 1'b0, 6'd20, 5'd2);
    check("rnd_ovf_data", 32'(o_data), 32'h2A00);
    // Exponent overflow saturates
    send(11'h400, 5'd0, 1'b1, 1'b1, 6'd63, 5'd3);
    check("sat_data", 32'(o_data), 32'hFFFF);
    check("ovf_cnt_1", 32'(o_ovf_cnt), 32'd1);
    // Underflow flushes to signed zero
    send(11'h5A3, 5'h1B, 1'b0, 1'b1, 6'd3, 5'd4);
    check("unf_data", 32'(o_data), 32'h8000);
    check("unf_cnt_1", 32'(o_unf_cnt), 32'd1);
    // Zero magnitude: no counter event
    send(11'h000, 5'h1B, 1'b0, 1'b0, 6'd3, 5'd5);
    check("zero_data", 32'(o_data), 32'h0000);
    check("zero_unf_cnt", 32'(o_unf_cnt), 32'd1);
    idle(1);
    i_clr_cnt = 1'b1;
    idle(1);
    i_clr_cnt = 1'b0;
    check("clr_unf_cnt", 32'(o_unf_cnt), 32'd0);
    check("clr_ovf_cnt", 32'(o_ovf_cnt), 32'd0);
    // Clear beats a same-cycle underflow increment
    i_clr_cnt = 1'b1;
    send(11'h400, 5'h10, 1'b0, 1'b0, 6'd2, 5'd6);
    i_clr_cnt = 1'b0;
    check("clr_prio_unf", 32'(o_unf_cnt), 32'd0);
    idle(3);
    check("drained", 32'(o_valid), 32'd0);

    // Backpressure: two fill the buffer, the third is held
    i_ready = 1'b0;
    send(11'h455, 5'd1, 1'b0, 1'b0, 6'd10, 5'd11);
    send(11'h4AA, 5'd2, 1'b0, 1'b1, 6'd11, 5'd12);
    check("bp_inhibit", 32'(o_inhibit), 32'd1);
    set_in(11'h6F0, 5'd3, 1'b1, 1'b0, 6'd12, 5'd13);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_hold_inhibit", 32'(o_inhibit), 32'd1);
      check("bp_head_q", 32'(o_Q_frac), 32'd11);
    end
    i_ready = 1'b1;
    wait_accept();
    idle(4);
    check("bp_drained", 32'(o_valid), 32'd0);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Random traffic with random downstream readiness
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [10:0] n;
      n = ($urandom_range(0, 9) == 0) ? 11'd0 : {1'b1, 10'($urandom())};
      send(n, 5'($urandom()), 1'($urandom()), 1'($urandom()), 6'($urandom()), 5'($urandom()));
    end
    rand_rdy = 1'b0;
    i_ready = 1'b1;
    idle(4);
    check("rand_ovf_cnt", 32'(o_ovf_cnt), 32'(m_ovf));
    check("rand_unf_cnt", 32'(o_unf_cnt), 32'(m_unf));
    check("rand_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset with the buffer full
    i_ready = 1'b0;
    send(11'h500, 5'd0, 1'b0, 1'b0, 6'd5, 5'd21);
    send(11'h600, 5'd0, 1'b0, 1'b0, 6'd6, 5'd22);
    i_valid = 1'b0;
    check("pre_rst_inhibit", 32'(o_inhibit), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_inhibit", 32'(o_inhibit), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_ready = 1'b1;
    idle(2);
    check("post_rst_valid", 32'(o_valid), 32'd0);
    check("post_rst_ovf", 32'(o_ovf_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
